vx_mem_credit_gate: RTL and testbench
=====================================

VX_MEM_CREDIT_GATE -- requirements
Module: VX_mem_credit_gate

Placement: between the cluster DRAM request/response ports and the next memory level. Limits outstanding reads to MAX_PENDING. Registers requests through a 2-entry buffer.

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 512, the DRAM line width in bits.
REQ-002 SHALL have parameter ADDR_WIDTH, default 26, the line address width.
REQ-003 SHALL have parameter TAG_WIDTH, default 8, the request/response tag width.
REQ-004 SHALL have parameter MAX_PENDING, default 16, the maximum outstanding reads (legal range 1..255).
REQ-005 SHALL have derived localparams BYTEEN_WIDTH = DATA_WIDTH/8 and CNT_WIDTH = $clog2(MAX_PENDING+1).
REQ-006 SHALL have port clk, input, 1, the single clock; all state is updated on its rising edge.
REQ-007 SHALL have port reset, input, 1, synchronous active-high reset.
REQ-008 SHALL have request-in ports, all inputs except ready:
- req_valid_in (1), req_rw_in (1; 1 = write), req_byteen_in (BYTEEN_WIDTH), req_addr_in (ADDR_WIDTH), req_data_in (DATA_WIDTH), req_tag_in (TAG_WIDTH);
- req_ready_in, output, 1.
REQ-009 SHALL have request-out ports, all outputs except ready, with the same fields and widths: req_valid_out, req_rw_out, req_byteen_out, req_addr_out, req_data_out, req_tag_out; plus req_ready_out, input, 1.
REQ-010 SHALL have response-in ports: rsp_valid_in (input, 1), rsp_data_in (input, DATA_WIDTH), rsp_tag_in (input, TAG_WIDTH), rsp_ready_in (output, 1).
REQ-011 SHALL have response-out ports: rsp_valid_out (output, 1), rsp_data_out (output, DATA_WIDTH), rsp_tag_out (output, TAG_WIDTH), rsp_ready_out (input, 1).
REQ-012 SHALL have status outputs:
- pending_count, output, CNT_WIDTH, the number of outstanding reads;
- busy, output, 1;
- underflow_err, output, 1, sticky.

Function
REQ-013 SHALL store accepted requests in a 2-entry FIFO holding {rw, byteen, addr, data, tag}, with no field modified.
REQ-014 SHALL drive req_ready_in = 1 when the FIFO holds fewer than 2 entries.
REQ-015 SHALL define an input fire as req_valid_in & req_ready_in; fired entries are accepted in order.
REQ-016 SHALL present the FIFO head on the req_*_out fields with no combinational path from the req_*_in fields, giving a minimum latency of 1 cycle from input fire to req_valid_out.
REQ-017 SHALL assert req_valid_out = FIFO non-empty & (head.rw | pending_count < MAX_PENDING).
REQ-018 SHALL define an output fire as req_valid_out & req_ready_out; an output fire pops the head.
REQ-019 SHALL allow a push and a pop in the same cycle, in every FIFO state, including when the FIFO is full; this sustains 1 request/cycle throughput.
REQ-020 SHALL increment pending_count by 1 on an output fire with rw = 0; write fires leave it unchanged.
REQ-021 SHALL decrement pending_count by 1 on a response fire, defined as rsp_valid_in & rsp_ready_out.
REQ-022 SHALL leave pending_count unchanged when a read output fire and a response fire occur in the same cycle.
REQ-023 SHALL hold a read head while pending_count == MAX_PENDING; there is no bypass or reordering, so later writes wait behind it.
REQ-024 SHALL, on a response fire with pending_count == 0 and no same-cycle read fire, hold pending_count at 0 and set underflow_err to 1 until reset.
REQ-025 SHALL pass responses through combinationally:
- rsp_valid_out = rsp_valid_in;
- rsp_data_out = rsp_data_in;
- rsp_tag_out = rsp_tag_in;
- rsp_ready_in = rsp_ready_out.
REQ-026 SHALL never let pending_count exceed MAX_PENDING.
REQ-027 SHALL drive busy = (pending_count != 0) | FIFO non-empty.
REQ-028 SHALL not drop an accepted request if req_valid_in deasserts or req_ready_out toggles; every fired request appears exactly once at the output.

Reset
REQ-029 SHALL, while reset is high at a clock edge, make the following values visible in the next cycle: FIFO empty, req_valid_out = 0, req_ready_in = 1, pending_count = 0, underflow_err = 0, busy = 0.
REQ-030 SHALL let reset asserted mid-operation discard all buffered requests and outstanding credits; responses arriving after reset count as underflow per REQ-024.
REQ-031 SHALL leave the req_*_out data fields unspecified while req_valid_out = 0.

Verification
REQ-032 Credit limit test:
- Stimulus: MAX_PENDING = 4, req_ready_out = 1, no responses; drive 6 reads with tags 0..5.
- Required: tags 0..3 exit on consecutive cycles; pending_count reaches 4; tag 4 is held with req_valid_out = 0; req_ready_in = 0 once 2 entries are buffered.
REQ-033 Release test:
- Stimulus: from REQ-032's end state, one response fire.
- Required: tag 4 fires in the next cycle, and pending_count returns to 4.
REQ-034 Write exemption test:
- Stimulus: pending_count = MAX_PENDING; FIFO holds a write (tag 9) at the head.
- Required: tag 9 fires immediately, and pending_count is unchanged.
REQ-035 Simultaneous event test:
- Stimulus: in the same cycle a read fires out and a response fires, with pending_count = 2.
- Required: pending_count stays 2.
REQ-036 Underflow test:
- Stimulus: after reset, a response fire with no prior read.
- Required: pending_count = 0, underflow_err = 1, and the response is passed through unchanged.
REQ-037 Back-pressure test:
- Stimulus: random req_ready_out at 30% duty; 200 random reads and writes; responses returned with random 1..20 cycle delay.
- Required: output order equals input order; no loss or duplication; pending_count ≤ MAX_PENDING throughout; busy = 0 at the end.

Source files
------------

// File: rtl/vx_mem_credit_gate.sv
// Credit gate between cluster DRAM ports and the next memory level: registers requests
// through a 2-entry FIFO and caps outstanding reads at MAX_PENDING; responses pass through.
module vx_mem_credit_gate #(
    parameter int DATA_WIDTH  = 512,
    parameter int ADDR_WIDTH  = 26,
    parameter int TAG_WIDTH   = 8,
    parameter int MAX_PENDING = 16,
    localparam int BYTEEN_WIDTH = DATA_WIDTH / 8,
    localparam int CNT_WIDTH    = $clog2(MAX_PENDING + 1)
) (
    input  logic                    clk,
    input  logic                    reset,

    input  logic                    req_valid_in,
    input  logic                    req_rw_in,
    input  logic [BYTEEN_WIDTH-1:0] req_byteen_in,
    input  logic [ADDR_WIDTH-1:0]   req_addr_in,
    input  logic [DATA_WIDTH-1:0]   req_data_in,
    input  logic [TAG_WIDTH-1:0]    req_tag_in,
    output logic                    req_ready_in,

    output logic                    req_valid_out,
    output logic                    req_rw_out,
    output logic [BYTEEN_WIDTH-1:0] req_byteen_out,
    output logic [ADDR_WIDTH-1:0]   req_addr_out,
    output logic [DATA_WIDTH-1:0]   req_data_out,
    output logic [TAG_WIDTH-1:0]    req_tag_out,
    input  logic                    req_ready_out,

    input  logic                    rsp_valid_in,
    input  logic [DATA_WIDTH-1:0]   rsp_data_in,
    input  logic [TAG_WIDTH-1:0]    rsp_tag_in,
    output logic                    rsp_ready_in,

    output logic                    rsp_valid_out,
    output logic [DATA_WIDTH-1:0]   rsp_data_out,
    output logic [TAG_WIDTH-1:0]    rsp_tag_out,
    input  logic                    rsp_ready_out,

    output logic [CNT_WIDTH-1:0]    pending_count,
    output logic                    busy,
    output logic                    underflow_err
);

    localparam int ENTRY_WIDTH = 1 + BYTEEN_WIDTH + ADDR_WIDTH + DATA_WIDTH + TAG_WIDTH;
    localparam logic [CNT_WIDTH-1:0] MAX_CNT = CNT_WIDTH'(MAX_PENDING);
    localparam logic [CNT_WIDTH-1:0] CNT_ONE = 1;

    logic [ENTRY_WIDTH-1:0] slot [2];
    logic                   rd_ptr;
    logic                   wr_ptr;
    logic [1:0]             count;

    logic [ENTRY_WIDTH-1:0] head;
    logic                   head_rw;
    logic                   in_fire;
    logic                   out_fire;
    logic                   read_fire;
    logic                   rsp_fire;

    assign head    = slot[rd_ptr];
    assign head_rw = head[ENTRY_WIDTH-1];

    assign {req_rw_out, req_byteen_out, req_addr_out, req_data_out, req_tag_out} = head;

    assign req_valid_out = (count != 2'd0) & (head_rw | (pending_count < MAX_CNT));
    assign out_fire      = req_valid_out & req_ready_out;
    // A full buffer still accepts when the head leaves this cycle, keeping 1 req/cycle.
    assign req_ready_in  = (count != 2'd2) | out_fire;
    assign in_fire       = req_valid_in & req_ready_in;

    assign read_fire = out_fire & ~head_rw;
    assign rsp_fire  = rsp_valid_in & rsp_ready_out;

    assign rsp_valid_out = rsp_valid_in;
    assign rsp_data_out  = rsp_data_in;
    assign rsp_tag_out   = rsp_tag_in;
    assign rsp_ready_in  = rsp_ready_out;

    assign busy = (pending_count != '0) | (count != 2'd0);

    always_ff @(posedge clk) begin
        if (in_fire) begin
            slot[wr_ptr] <= {req_rw_in, req_byteen_in, req_addr_in, req_data_in, req_tag_in};
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            rd_ptr <= 1'b0;
            wr_ptr <= 1'b0;
            count  <= 2'd0;
        end else begin
            if (in_fire) begin
                wr_ptr <= ~wr_ptr;
            end
            if (out_fire) begin
                rd_ptr <= ~rd_ptr;
            end
            case ({in_fire, out_fire})
                2'b10:   count <= count + 2'd1;
                2'b01:   count <= count - 2'd1;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            pending_count <= '0;
            underflow_err <= 1'b0;
        end else if (read_fire && !rsp_fire) begin
            pending_count <= pending_count + CNT_ONE;
        end else if (rsp_fire && !read_fire) begin
            // A response with no credit outstanding is a protocol error; never wrap.
            if (pending_count == '0) begin
                underflow_err <= 1'b1;
            end else begin
                pending_count <= pending_count - CNT_ONE;
            end
        end
    end

endmodule

// File: tb/tb_vx_mem_credit_gate.sv
// Bench for vx_mem_credit_gate: directed credit/release/write/underflow steps followed by
// a randomized back-pressure run, all checked against a queue-based reference model.
module tb_vx_mem_credit_gate;

    localparam int DW   = 64;
    localparam int AW   = 26;
    localparam int TW   = 8;
    localparam int MAXP = 4;
    localparam int BW   = DW / 8;
    localparam int CW   = $clog2(MAXP + 1);
    localparam int EW   = 1 + BW + AW + DW + TW;
    localparam int CYC_LIMIT = 20000;

    typedef logic [EW-1:0] ent_t;

    logic          clk;
    logic          reset;
    logic          req_valid_in;
    logic          req_rw_in;
    logic [BW-1:0] req_byteen_in;
    logic [AW-1:0] req_addr_in;
    logic [DW-1:0] req_data_in;
    logic [TW-1:0] req_tag_in;
    logic          req_ready_in;
    logic          req_valid_out;
    logic          req_rw_out;
    logic [BW-1:0] req_byteen_out;
    logic [AW-1:0] req_addr_out;
    logic [DW-1:0] req_data_out;
    logic [TW-1:0] req_tag_out;
    logic          req_ready_out;
    logic          rsp_valid_in;
    logic [DW-1:0] rsp_data_in;
    logic [TW-1:0] rsp_tag_in;
    logic          rsp_ready_in;
    logic          rsp_valid_out;
    logic [DW-1:0] rsp_data_out;
    logic [TW-1:0] rsp_tag_out;
    logic          rsp_ready_out;
    logic [CW-1:0] pending_count;
    logic          busy;
    logic          underflow_err;

    vx_mem_credit_gate #(
        .DATA_WIDTH (DW),
        .ADDR_WIDTH (AW),
        .TAG_WIDTH  (TW),
        .MAX_PENDING(MAXP)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .req_valid_in  (req_valid_in),
        .req_rw_in     (req_rw_in),
        .req_byteen_in (req_byteen_in),
        .req_addr_in   (req_addr_in),
        .req_data_in   (req_data_in),
        .req_tag_in    (req_tag_in),
        .req_ready_in  (req_ready_in),
        .req_valid_out (req_valid_out),
        .req_rw_out    (req_rw_out),
        .req_byteen_out(req_byteen_out),
        .req_addr_out  (req_addr_out),
        .req_data_out  (req_data_out),
        .req_tag_out   (req_tag_out),
        .req_ready_out (req_ready_out),
        .rsp_valid_in  (rsp_valid_in),
        .rsp_data_in   (rsp_data_in),
        .rsp_tag_in    (rsp_tag_in),
        .rsp_ready_in  (rsp_ready_in),
        .rsp_valid_out (rsp_valid_out),
        .rsp_data_out  (rsp_data_out),
        .rsp_tag_out   (rsp_tag_out),
        .rsp_ready_out (rsp_ready_out),
        .pending_count (pending_count),
        .busy          (busy),
        .underflow_err (underflow_err)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int   n_cmp = 0;
    int   n_err = 0;
    int   cyc = 0;
    bit   model_valid = 1'b0;
    ent_t mq[$];
    int   m_pend = 0;
    bit   m_uf = 1'b0;
    int   dut_out_tags[$];
    int   dut_out_cycs[$];

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_cmp++;
        assert (obs === exp)
        else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    // One clock: check DUT against the model at the negedge, then advance the model at the posedge.
    task automatic cycle(output bit in_f, output bit out_f, output bit out_rw);
        bit   vld;
        bit   rdy;
        bit   rspf;
        bit   hrw;
        ent_t hd;
        ent_t inent;
        @(negedge clk);
        hd    = (mq.size() > 0) ? mq[0] : '0;
        hrw   = hd[EW-1];
        vld   = (mq.size() > 0) && (hrw || m_pend < MAXP);
        out_f = vld && req_ready_out;
        rdy   = (mq.size() < 2) || out_f;
        in_f  = req_valid_in && rdy;
        rspf  = rsp_valid_in && rsp_ready_out;
        out_rw = hrw;
        inent = {req_rw_in, req_byteen_in, req_addr_in, req_data_in, req_tag_in};
        if (model_valid) begin
            check("ready_in", 128'(req_ready_in), 128'(rdy));
            check("valid_out", 128'(req_valid_out), 128'(vld));
            if (vld)
                check("out_entry", 128'({req_rw_out, req_byteen_out, req_addr_out,
                                         req_data_out, req_tag_out}), 128'(hd));
            check("pending", 128'(pending_count), 128'(m_pend));
            check("pend_le_max", 128'(pending_count <= CW'(MAXP)), 128'(1));
            check("underflow", 128'(underflow_err), 128'(m_uf));
            check("busy", 128'(busy), 128'((m_pend != 0) || (mq.size() > 0)));
            check("rsp_valid_pass", 128'(rsp_valid_out), 128'(rsp_valid_in));
            check("rsp_data_pass", 128'(rsp_data_out), 128'(rsp_data_in));
            check("rsp_tag_pass", 128'(rsp_tag_out), 128'(rsp_tag_in));
            check("rsp_ready_pass", 128'(rsp_ready_in), 128'(rsp_ready_out));
            if (req_valid_out === 1'b1 && req_ready_out) begin
                dut_out_tags.push_back(int'(req_tag_out));
                dut_out_cycs.push_back(cyc);
            end
        end
        @(posedge clk);
        if (reset) begin
            mq.delete();
            m_pend = 0;
            m_uf = 1'b0;
            model_valid = 1'b1;
            in_f = 1'b0;
            out_f = 1'b0;
        end else begin
            if (out_f) void'(mq.pop_front());
            if (in_f) mq.push_back(inent);
            if (out_f && !hrw && !rspf) m_pend++;
            else if (rspf && !(out_f && !hrw)) begin
                if (m_pend == 0) m_uf = 1'b1;
                else m_pend--;
            end
        end
        cyc++;
        #1;
    endtask

    task automatic drive_req(input bit rw, input int tag);
        req_valid_in  = 1'b1;
        req_rw_in     = rw;
        req_byteen_in = BW'($urandom);
        req_addr_in   = AW'($urandom);
        req_data_in   = {$urandom, $urandom};
        req_tag_in    = TW'(tag);
    endtask

    initial begin
        bit fi, fo, frw;
        int tag, guard, k, n_sent, base_out;
        int due_q[$];

        reset = 1'b1;
        req_valid_in = 1'b0; req_rw_in = 1'b0; req_byteen_in = '0; req_addr_in = '0;
        req_data_in = '0; req_tag_in = '0; req_ready_out = 1'b1;
        rsp_valid_in = 1'b0; rsp_data_in = '0; rsp_tag_in = '0; rsp_ready_out = 1'b1;

        repeat (2) cycle(fi, fo, frw);
        reset = 1'b0;
        check("rst_ready_in", 128'(req_ready_in), 128'(1));
        check("rst_valid_out", 128'(req_valid_out), 128'(0));
        check("rst_pending", 128'(pending_count), 128'(0));
        check("rst_underflow", 128'(underflow_err), 128'(0));
        check("rst_busy", 128'(busy), 128'(0));

        // Credit limit: six reads, only four may leave.
        tag = 0; guard = 0;
        dut_out_tags.delete(); dut_out_cycs.delete();
        while (tag < 6 && guard < 50) begin
            drive_req(1'b0, tag);
            cycle(fi, fo, frw);
            if (fi) tag++;
            guard++;
        end
        req_valid_in = 1'b0;
        repeat (3) cycle(fi, fo, frw);
        check("credit_sent", 128'(tag), 128'(6));
        check("credit_out_n", 128'(dut_out_tags.size()), 128'(4));
        if (dut_out_tags.size() == 4) begin
            for (int i = 0; i < 4; i++) begin
                check("credit_out_tag", 128'(dut_out_tags[i]), 128'(i));
                check("credit_out_cyc", 128'(dut_out_cycs[i]), 128'(dut_out_cycs[0] + i));
            end
        end
        check("credit_pending", 128'(pending_count), 128'(4));
        check("credit_held_valid", 128'(req_valid_out), 128'(0));
        check("credit_held_tag", 128'(req_tag_out), 128'(4));
        check("credit_full_ready", 128'(req_ready_in), 128'(0));

        // Release: one response lets tag 4 out on the next cycle.
        rsp_valid_in = 1'b1; rsp_tag_in = 8'h44; rsp_data_in = {$urandom, $urandom};
        k = cyc;
        cycle(fi, fo, frw);
        rsp_valid_in = 1'b0;
        check("release_pend_dip", 128'(pending_count), 128'(3));
        cycle(fi, fo, frw);
        check("release_tag", 128'(dut_out_tags[$]), 128'(4));
        check("release_cyc", 128'(dut_out_cycs[$]), 128'(k + 1));
        check("release_pending", 128'(pending_count), 128'(4));

        // Write exemption: write tag 9 goes out while credits are exhausted.
        drive_req(1'b1, 9);
        cycle(fi, fo, frw);
        check("wr_accept", 128'(fi), 128'(1));
        req_valid_in = 1'b0;
        rsp_valid_in = 1'b1;
        cycle(fi, fo, frw);
        rsp_valid_in = 1'b0;
        cycle(fi, fo, frw);
        check("wr_head_valid", 128'(req_valid_out), 128'(1));
        check("wr_head_tag", 128'(req_tag_out), 128'(9));
        check("wr_head_pending", 128'(pending_count), 128'(4));
        cycle(fi, fo, frw);
        check("wr_out_tag", 128'(dut_out_tags[$]), 128'(9));
        check("wr_pending_kept", 128'(pending_count), 128'(4));

        // Simultaneous read fire and response fire at pending 2.
        rsp_valid_in = 1'b1;
        repeat (2) cycle(fi, fo, frw);
        rsp_valid_in = 1'b0;
        drive_req(1'b0, 7);
        cycle(fi, fo, frw);
        req_valid_in = 1'b0;
        check("sim_pre_pending", 128'(pending_count), 128'(2));
        check("sim_pre_valid", 128'(req_valid_out), 128'(1));
        rsp_valid_in = 1'b1;
        cycle(fi, fo, frw);
        rsp_valid_in = 1'b0;
        check("sim_tag", 128'(dut_out_tags[$]), 128'(7));
        check("sim_pending", 128'(pending_count), 128'(2));
        rsp_valid_in = 1'b1;
        repeat (2) cycle(fi, fo, frw);
        rsp_valid_in = 1'b0;
        cycle(fi, fo, frw);
        check("drain_busy", 128'(busy), 128'(0));

        // Underflow: response after reset with no read outstanding.
        reset = 1'b1;
        cycle(fi, fo, frw);
        reset = 1'b0;
        rsp_valid_in = 1'b1; rsp_data_in = {$urandom, $urandom}; rsp_tag_in = TW'($urandom);
        #1;
        check("uf_pass_data", 128'(rsp_data_out), 128'(rsp_data_in));
        check("uf_pass_tag", 128'(rsp_tag_out), 128'(rsp_tag_in));
        check("uf_pass_valid", 128'(rsp_valid_out), 128'(1));
        cycle(fi, fo, frw);
        rsp_valid_in = 1'b0;
        check("uf_pending", 128'(pending_count), 128'(0));
        check("uf_flag", 128'(underflow_err), 128'(1));
        repeat (2) cycle(fi, fo, frw);
        check("uf_sticky", 128'(underflow_err), 128'(1));

        // Random back-pressure run.
        reset = 1'b1;
        cycle(fi, fo, frw);
        reset = 1'b0;
        n_sent = 0;
        base_out = dut_out_tags.size();
        due_q.delete();
        while ((n_sent < 200 || mq.size() > 0 || m_pend > 0) && cyc < CYC_LIMIT) begin
            if (n_sent < 200) begin
                if (!req_valid_in) drive_req(1'($urandom), int'($urandom_range(0, 255)));
            end else begin
                req_valid_in = 1'b0;
            end
            req_ready_out = ($urandom_range(0, 9) < 3);
            rsp_ready_out = ($urandom_range(0, 3) != 0);
            rsp_valid_in  = (due_q.size() > 0) && (due_q[0] <= cyc);
            rsp_tag_in    = TW'($urandom);
            rsp_data_in   = {$urandom, $urandom};
            k = cyc;
            cycle(fi, fo, frw);
            if (rsp_valid_in && rsp_ready_out) void'(due_q.pop_front());
            if (fi) begin
                n_sent++;
                req_valid_in = 1'b0;
            end
            if (fo && !frw) due_q.push_back(k + int'($urandom_range(1, 20)));
        end
        req_valid_in = 1'b0; rsp_valid_in = 1'b0; req_ready_out = 1'b1; rsp_ready_out = 1'b1;
        check("rand_timeout", 128'(cyc < CYC_LIMIT), 128'(1));
        check("rand_sent", 128'(n_sent), 128'(200));
        check("rand_out_count", 128'(dut_out_tags.size() - base_out), 128'(200));
        cycle(fi, fo, frw);
        check("rand_end_busy", 128'(busy), 128'(0));
        check("rand_end_pending", 128'(pending_count), 128'(0));
        check("rand_no_underflow", 128'(underflow_err), 128'(0));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
